// File: rtl/intr_pkg.sv
// Shared types and constants for the intr_ctrl interrupt controller.
package intr_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_REQ     = 2'd1,
      ST_SERVICE = 2'd2
   } intr_state_t;

   localparam logic [9:0]  DEF_VEC_BASE   = 10'd860;
   localparam int unsigned DEF_VEC_STRIDE = 32'd20;

   // Width of a source index; a single-source build still needs one bit.
   function automatic int id_width(input int n);
      if (n > 1) begin
         return $clog2(n);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/intr_prio_enc.sv
// Combinational lowest-index-first priority encoder for intr_ctrl.
module intr_prio_enc #(
   parameter int N    = 8,
   parameter int ID_W = 3
) (
   input  logic [N-1:0]    req,
   output logic            valid,
   output logic [ID_W-1:0] id
);

   logic [N-1:0] lowest_s;

   // Isolate the lowest set bit, then OR-encode its position.
   always_comb begin
      lowest_s = req & (~req + N'(1));
      valid    = |req;
      id       = {ID_W{1'b0}};
      for (int i = 0; i < N; i++) begin
         id = id | (lowest_s[i] ? ID_W'(i) : {ID_W{1'b0}});
      end
   end

endmodule

// File: rtl/intr_ctrl.sv
// Edge-triggered interrupt controller with enable mask, fixed priority and req/ack/done handshake.
// Optional INTR_SYNC_EN adds a two-flop synchroniser on intr_in.
module intr_ctrl
   import intr_pkg::*;
#(
   parameter int                 N_SRC      = 8,
   parameter int                 ADDR_W     = 10,
   parameter logic [ADDR_W-1:0]  VEC_BASE   = ADDR_W'(DEF_VEC_BASE),
   parameter int unsigned        VEC_STRIDE = DEF_VEC_STRIDE,
   parameter logic [N_SRC-1:0]   EN_RST     = {N_SRC{1'b1}}
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [N_SRC-1:0]              intr_in,
   input  logic                          intr_en_we,
   input  logic [N_SRC-1:0]              intr_en_in,
   input  logic                          intr_ack,
   input  logic                          intr_done,
   output logic                          intr_req,
   output logic [ADDR_W-1:0]             intr_dir_out,
   output logic [id_width(N_SRC)-1:0]    intr_id,
   output logic                          busy,
   output logic [N_SRC-1:0]              pending_out
);

   localparam int ID_W  = id_width(N_SRC);
   localparam int VEC_W = ADDR_W + 8;

   logic [N_SRC-1:0]  line_s;
   logic [N_SRC-1:0]  intr_prev_r;
   logic [N_SRC-1:0]  rise_s;
   logic [N_SRC-1:0]  clr_s;
   logic [N_SRC-1:0]  pending_r;
   logic [N_SRC-1:0]  pending_nxt_s;
   logic [N_SRC-1:0]  en_mask_r;
   logic [N_SRC-1:0]  enabled_s;
   logic              win_valid_s;
   logic [ID_W-1:0]   win_id_s;
   logic [ADDR_W-1:0] win_vec_s;
   intr_state_t       state_r;
   intr_state_t       state_nxt_s;

   // Vector is formed with headroom and then truncated to the address width.
   function automatic logic [ADDR_W-1:0] vec_addr(input logic [ID_W-1:0] src);
      return ADDR_W'(VEC_W'(VEC_BASE) + VEC_W'(src) * VEC_W'(VEC_STRIDE));
   endfunction

`ifdef INTR_SYNC_EN
   logic [N_SRC-1:0] sync1_r;
   logic [N_SRC-1:0] sync2_r;

   // Two-flop synchroniser; resets high so a line held high across reset stays quiet.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_r <= {N_SRC{1'b1}};
         sync2_r <= {N_SRC{1'b1}};
      end else begin
         sync1_r <= intr_in;
         sync2_r <= sync1_r;
      end
   end

   assign line_s = sync2_r;
`else
   assign line_s = intr_in;
`endif

   // Edge history, pending latches and enable mask.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         intr_prev_r <= {N_SRC{1'b1}};
         pending_r   <= {N_SRC{1'b0}};
         en_mask_r   <= EN_RST;
      end else begin
         intr_prev_r <= line_s;
         pending_r   <= pending_nxt_s;
         if (intr_en_we) begin
            en_mask_r <= intr_en_in;
         end else begin
            en_mask_r <= en_mask_r;
         end
      end
   end

   // New rising edges win over the acknowledge clear of the same bit.
   always_comb begin
      rise_s = line_s & ~intr_prev_r;
      if ((state_r == ST_REQ) && intr_ack) begin
         clr_s = N_SRC'(1) << intr_id;
      end else begin
         clr_s = {N_SRC{1'b0}};
      end
      pending_nxt_s = (pending_r & ~clr_s) | rise_s;
      enabled_s     = pending_r & en_mask_r;
   end

   intr_prio_enc #(
      .N    (N_SRC),
      .ID_W (ID_W)
   ) u_prio_enc (
      .req   (enabled_s),
      .valid (win_valid_s),
      .id    (win_id_s)
   );

   assign win_vec_s = vec_addr(win_id_s);

   // Next-state logic for the request handshake.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (win_valid_s) begin
               state_nxt_s = ST_REQ;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (intr_ack) begin
               state_nxt_s = ST_SERVICE;
            end else begin
               state_nxt_s = ST_REQ;
            end
         end
         ST_SERVICE: begin
            if (intr_done) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s = ST_SERVICE;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // State register and registered CPU-facing outputs; id/vector frozen outside IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r      <= ST_IDLE;
         intr_req     <= 1'b0;
         busy         <= 1'b0;
         intr_id      <= {ID_W{1'b0}};
         intr_dir_out <= {ADDR_W{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         intr_req <= (state_nxt_s == ST_REQ);
         busy     <= (state_nxt_s == ST_SERVICE);
         if ((state_r == ST_IDLE) && win_valid_s) begin
            intr_id      <= win_id_s;
            intr_dir_out <= win_vec_s;
         end else begin
            intr_id      <= intr_id;
            intr_dir_out <= intr_dir_out;
         end
      end
   end

   assign pending_out = pending_r;

endmodule

// File: doc/intr_ctrl.md
# intr_ctrl

Parametrised interrupt controller sitting between the external interrupt lines and the CPU's PC-load logic. It edge-detects up to N_SRC sources into pending latches, applies a software-writable enable mask, and selects the highest-priority request (lowest index wins). It presents a stable vector address and source id to the CPU under a req/ack handshake, then blocks further requests until the CPU signals end of service.

## Interface
- N_SRC, 8: number of interrupt sources (1..32)
- ADDR_W, 10: vector address width
- VEC_BASE, 10'd860: vector address of source 0
- VEC_STRIDE, 20: address distance between consecutive vectors
- EN_RST, all ones: reset value of the enable mask
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- intr_in  in  N_SRC  raw interrupt lines, rising-edge significant
- intr_en_we  in  1  write strobe for the enable mask
- intr_en_in  in  N_SRC  new enable mask (1 = source enabled)
- intr_ack  in  1  CPU accepts the presented vector
- intr_done  in  1  CPU finished the service routine (return from interrupt)
- intr_req  out  1  request to CPU
- intr_dir_out  out  ADDR_W  vector address, valid while intr_req=1
- intr_id  out  $clog2(N_SRC)  index of the presented source
- busy  out  1  service in progress
- pending_out  out  N_SRC  pending latches, for status reads

## Operation
- Edge detect: intr_prev registers the (optionally synchronised) lines; rise = line & ~intr_prev sets pending[i].
- Enabled set = pending & en_mask. Masked sources stay pending and fire once enabled.
- FSM: IDLE, REQ, SERVICE.
  - IDLE: if enabled set ≠ 0, latch the winning id and vector, then go to REQ.
  - REQ: intr_req=1; id/vector held stable regardless of new edges or mask writes. intr_ack clears pending[id], sets busy, and moves to SERVICE.
  - SERVICE: no requests (no nesting). intr_done returns the FSM to IDLE and clears busy.
- intr_ack outside REQ and intr_done outside SERVICE are ignored.
- Vector = VEC_BASE + id*VEC_STRIDE, computed in ADDR_W+8 bits and truncated to ADDR_W. Defaults give 860, 880, …, 1000.
- Same-cycle set and clear on one pending bit: set wins (new event kept).
- intr_en_we takes effect at the next edge; the write does not alter a latched REQ.

## Timing
- Reset values: intr_req=0, intr_dir_out=0, intr_id=0, busy=0, pending=0, en_mask=EN_RST, intr_prev=all ones, FSM=IDLE.
  - Because intr_prev resets to all ones, a line held high through reset does not fire.
- Latency without sync: rising edge first sampled at edge n, so pending is set after edge n and intr_req=1 after edge n+1.
- intr_ack sampled at edge m drops intr_req and raises busy after edge m.
- intr_done sampled at edge p returns the FSM to IDLE after edge p. The next request, if any, appears after edge p+1.
- Reset asserted mid-operation drops everything to reset values immediately; pending events are lost.

## Configuration
- INTR_SYNC_EN defined: a two-flop synchroniser is placed on intr_in before edge detection. Latency grows by 2 cycles (intr_req after edge n+3). Synchroniser flops reset to all ones.
- Not defined: intr_in feeds edge detection directly; inputs must be synchronous to clk.

## Structure
- Package intr_pkg: FSM state typedef (IDLE/REQ/SERVICE), default VEC_BASE/VEC_STRIDE constants, and an id-width function.
- Sub-module intr_prio_enc: combinational N_SRC-wide lowest-index-first priority encoder producing a valid flag and an id.

## Test plan
- Pulse intr_in[0] at edge n -> intr_req=1 after edge n+1, intr_dir_out=860, intr_id=0; ack -> busy=1, pending_out[0]=0.
- Raise intr_in[7] and intr_in[2] in the same cycle -> vector 900 (id 2) first; after done, vector 1000 (id 7).
- Enable mask 8'hFE, pulse intr_in[0] -> no intr_req, pending_out[0]=1; write mask 8'hFF -> intr_req with vector 860.
- In SERVICE, pulse intr_in[1] -> intr_req stays 0 until intr_done; one cycle after the FSM returns to IDLE, intr_req=1 with vector 880.
- Assert reset during REQ -> all outputs 0 immediately, pending cleared; a line held high through reset release -> no request.
- With INTR_SYNC_EN, pulse intr_in[3] -> intr_req after edge n+3, vector 920.
